// File: rtl/bnn_pkg.sv
// Shared types and helpers for the multi-word BNN neuron sequencer.
package bnn_pkg;

  localparam int unsigned BNN_WORD_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_A,
    S_WAIT_A,
    S_REQ_W,
    S_WAIT_W,
    S_RESULT
  } bnn_seq_state_t;

  // Lower-bits mask: bits [valid_bits-1:0] set, 32 or more gives all-ones.
  function automatic logic [BNN_WORD_W-1:0] bnn_word_mask(input logic [5:0] valid_bits);
    logic [BNN_WORD_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < BNN_WORD_W; i++) begin
      if (i < 32'(valid_bits)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/bnn_word_pop.sv
// One-word masked XNOR popcount.
module bnn_word_pop
  import bnn_pkg::*;
(
  input  logic [BNN_WORD_W-1:0] act,
  input  logic [BNN_WORD_W-1:0] wgt,
  input  logic [5:0]            valid_bits,
  output logic [5:0]            count
);

  logic [BNN_WORD_W-1:0] x;

  // XNOR the operands, drop bits beyond the valid width, count the ones.
  always_comb begin
    x     = ~(act ^ wgt) & bnn_word_mask(valid_bits);
    count = '0;
    for (int unsigned i = 0; i < BNN_WORD_W; i++) begin
      count = count + 6'(x[i]);
    end
  end

endmodule

// File: rtl/bnn_neuron_seq.sv
// Multi-word BNN neuron sequencer: fetches activation/weight words one at a
// time, accumulates masked XNOR popcounts and returns 2*pop-N or a threshold bit.
module bnn_neuron_seq
  import bnn_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_BITS = 1024,
  localparam int unsigned NB_W    = $clog2(MAX_BITS) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] act_base_i,
  input  logic [ADDR_W-1:0] wgt_base_i,
  input  logic [NB_W-1:0]   n_bits_i,
  input  logic [31:0]       threshold_i,
  input  logic              en_threshold_i,
  output logic              busy_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [31:0]       res_data_o
);

  bnn_seq_state_t state_q, state_d;

  logic [ADDR_W-1:0] act_base_q, wgt_base_q;
  logic [NB_W-1:0]   n_q, k_q, acc_q, acc_sum;
  logic [31:0]       thr_q, act_q, res_q, c32;
  logic              en_th_q, err_q;
  logic              n_legal, last_word, activation;
  logic [5:0]        valid_bits, pop_cnt;
  logic [NB_W:0]     c_wide;
  logic [ADDR_W-1:0] act_addr, wgt_addr;

  bnn_word_pop u_pop (
    .act        (act_q),
    .wgt        (mem_rdata_i),
    .valid_bits (valid_bits),
    .count      (pop_cnt)
  );

  // Word bookkeeping, addresses and the final signed result.
  always_comb begin
    n_legal    = (n_bits_i != '0) && (32'(n_bits_i) <= MAX_BITS);
    last_word  = (k_q == ((n_q - 1'b1) >> 5));
    valid_bits = last_word ? 6'(n_q - (k_q << 5)) : 6'd32;
    acc_sum    = acc_q + NB_W'(pop_cnt);
    c_wide     = {acc_sum, 1'b0} - {1'b0, n_q};
    c32        = {{(32-NB_W-1){c_wide[NB_W]}}, c_wide};
    activation = $signed(c32) >= $signed(thr_q);
    act_addr   = act_base_q + (ADDR_W'(k_q) << 2);
    wgt_addr   = wgt_base_q + (ADDR_W'(k_q) << 2);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    mem_req_o   = 1'b0;
    mem_addr_o  = {act_addr[ADDR_W-1:2], 2'b00};
    busy_o      = (state_q != S_IDLE);
    res_valid_o = 1'b0;
    unique case (state_q)
      S_IDLE:   if (start_i && n_legal) state_d = S_REQ_A;
      S_REQ_A: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_d = S_WAIT_A;
      end
      S_WAIT_A: if (mem_rvalid_i) state_d = S_REQ_W;
      S_REQ_W: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {wgt_addr[ADDR_W-1:2], 2'b00};
        if (mem_gnt_i) state_d = S_WAIT_W;
      end
      S_WAIT_W: if (mem_rvalid_i) state_d = last_word ? S_RESULT : S_REQ_A;
      S_RESULT: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Command capture, word capture, accumulation and result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_base_q <= '0;
      wgt_base_q <= '0;
      n_q        <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      thr_q      <= '0;
      act_q      <= '0;
      res_q      <= '0;
      en_th_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= (state_q == S_IDLE) && start_i && !n_legal;
      unique case (state_q)
        S_IDLE: if (start_i && n_legal) begin
          act_base_q <= act_base_i;
          wgt_base_q <= wgt_base_i;
          n_q        <= n_bits_i;
          thr_q      <= threshold_i;
          en_th_q    <= en_threshold_i;
          k_q        <= '0;
          acc_q      <= '0;
        end
        S_WAIT_A: if (mem_rvalid_i) act_q <= mem_rdata_i;
        S_WAIT_W: if (mem_rvalid_i) begin
          acc_q <= acc_sum;
          if (last_word) res_q <= en_th_q ? {31'b0, activation} : c32;
          else           k_q   <= k_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign err_o      = err_q;
  assign res_data_o = res_q;

endmodule

// File: tb/tb_bnn_neuron_seq.sv
// Directed bench for bnn_neuron_seq with a single-outstanding memory model.
module tb_bnn_neuron_seq;

  localparam logic [31:0] ACT_BASE = 32'h0000_1000;
  localparam logic [31:0] WGT_BASE = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] act_base, wgt_base;
  logic [10:0] n_bits;
  logic [31:0] threshold;
  logic        en_th;
  logic        busy_o, err_o, mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        res_valid_o, res_ready;
  logic [31:0] res_data_o;

  logic [31:0] act_mem [32];
  logic [31:0] wgt_mem [32];
  logic [31:0] addr_log [$];
  int          gnt_delay;
  int          ngnt;
  int          cyc;
  int          n_tests;
  int          n_fail;

  bnn_neuron_seq #(.ADDR_W(32), .MAX_BITS(1024)) dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start),
    .act_base_i     (act_base),
    .wgt_base_i     (wgt_base),
    .n_bits_i       (n_bits),
    .threshold_i    (threshold),
    .en_threshold_i (en_th),
    .busy_o         (busy_o),
    .err_o          (err_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_gnt_i      (mem_gnt),
    .mem_rvalid_i   (mem_rvalid),
    .mem_rdata_i    (mem_rdata),
    .res_valid_o    (res_valid_o),
    .res_ready_i    (res_ready),
    .res_data_o     (res_data_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lookup(input logic [31:0] a);
    logic [31:0] off;
    if (a >= WGT_BASE) begin
      off = (a - WGT_BASE) >> 2;
      return wgt_mem[off[4:0]];
    end
    off = (a - ACT_BASE) >> 2;
    return act_mem[off[4:0]];
  endfunction

  // Memory model: grant after gnt_delay waiting cycles, data one cycle later.
  initial begin : mem_model
    logic        pend;
    logic [31:0] paddr, first_addr;
    int          wcnt;
    pend = 1'b0; paddr = '0; first_addr = '0; wcnt = 0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (pend) begin
        mem_rvalid = 1'b1;
        mem_rdata  = lookup(paddr);
        pend       = 1'b0;
      end
      if (mem_req_o && !reset) begin
        if (wcnt == 0) first_addr = mem_addr_o;
        else check("addr_stable", mem_addr_o, first_addr);
        if (wcnt == gnt_delay) begin
          mem_gnt = 1'b1;
          paddr   = mem_addr_o;
          pend    = 1'b1;
          wcnt    = 0;
          addr_log.push_back(mem_addr_o);
          ngnt++;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // One neuron from start to result handshake; poke adds starts while busy.
  task automatic run(input string tag, input logic [10:0] n, input logic [31:0] thr,
                     input logic en, input logic [31:0] exp, input int lat,
                     input int rdy_dly, input bit poke);
    int t0;
    bit seen;
    @(negedge clk);
    addr_log.delete();
    n_bits = n; threshold = thr; en_th = en; start = 1'b1;
    t0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      start = poke && (i == 1);
      if (i == 0) begin
        n_bits = 11'd5; threshold = 32'd1000; en_th = ~en;
      end
      if (res_valid_o) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) begin
      check({tag, "_valid"}, {31'b0, res_valid_o}, 32'd1);
    end else begin
      if (lat > 0) check({tag, "_lat"}, cyc - t0, lat);
      check({tag, "_busy"}, {31'b0, busy_o}, 32'd1);
      check({tag, "_data"}, res_data_o, exp);
      repeat (rdy_dly) begin
        @(negedge clk);
        check({tag, "_hold_valid"}, {31'b0, res_valid_o}, 32'd1);
        check({tag, "_hold_busy"}, {31'b0, busy_o}, 32'd1);
        check({tag, "_hold_data"}, res_data_o, exp);
      end
      res_ready = 1'b1;
      start     = poke;
      @(negedge clk);
      res_ready = 1'b0;
      start     = 1'b0;
      check({tag, "_valid_drop"}, {31'b0, res_valid_o}, 32'd0);
      check({tag, "_busy_drop"}, {31'b0, busy_o}, 32'd0);
      if (poke) begin
        @(negedge clk);
        check({tag, "_late_start_busy"}, {31'b0, busy_o}, 32'd0);
        check({tag, "_late_start_req"}, {31'b0, mem_req_o}, 32'd0);
      end
    end
  endtask

  task automatic bad_start(input string tag, input logic [10:0] n);
    int g0;
    g0 = ngnt;
    @(negedge clk);
    n_bits = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_err"}, {31'b0, err_o}, 32'd1);
    check({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
    @(negedge clk);
    check({tag, "_err_pulse"}, {31'b0, err_o}, 32'd0);
    repeat (3) begin
      check({tag, "_no_req"}, {31'b0, mem_req_o}, 32'd0);
      @(negedge clk);
    end
    check({tag, "_no_gnt"}, ngnt - g0, 32'd0);
  endtask

  initial begin
    int g0;
    n_tests = 0; n_fail = 0; cyc = 0; ngnt = 0; gnt_delay = 0;
    reset = 1'b1; start = 1'b0; res_ready = 1'b0;
    act_base = ACT_BASE; wgt_base = WGT_BASE;
    n_bits = '0; threshold = '0; en_th = 1'b0;
    for (int i = 0; i < 32; i++) begin act_mem[i] = '0; wgt_mem[i] = '0; end

    #3;
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_err", {31'b0, err_o}, 32'd0);
    check("rst_req", {31'b0, mem_req_o}, 32'd0);
    check("rst_valid", {31'b0, res_valid_o}, 32'd0);
    check("rst_data", res_data_o, 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // N=9, identical operands: pop 9, c = 9.
    act_mem[0] = 32'h1FF; wgt_mem[0] = 32'h1FF;
    run("n9_eq", 11'd9, 32'd0, 1'b0, 32'h0000_0009, 5, 0, 1'b0);
    check("n9_nreq", addr_log.size(), 32'd2);
    if (addr_log.size() == 2) begin
      check("n9_addr0", addr_log[0], ACT_BASE);
      check("n9_addr1", addr_log[1], WGT_BASE);
    end

    // N=9, all-differing: c = -9.
    act_mem[0] = 32'h000; wgt_mem[0] = 32'h1FF;
    run("n9_neg", 11'd9, 32'd0, 1'b0, 32'hFFFF_FFF7, 5, 0, 1'b0);
    run("n9_th0", 11'd9, 32'd0, 1'b1, 32'd0, 5, 0, 1'b0);
    run("n9_thm9", 11'd9, 32'hFFFF_FFF7, 1'b1, 32'd1, 5, 0, 1'b0);

    // N=40: word0 all match (32), word1 only 8 valid bits, all differ -> c = 24.
    act_mem[0] = 32'hFFFF_FFFF; wgt_mem[0] = 32'hFFFF_FFFF;
    act_mem[1] = 32'h0000_0000; wgt_mem[1] = 32'h0000_00FF;
    run("n40", 11'd40, 32'd0, 1'b0, 32'd24, 9, 0, 1'b0);
    check("n40_nreq", addr_log.size(), 32'd4);
    if (addr_log.size() == 4) begin
      check("n40_addr0", addr_log[0], ACT_BASE);
      check("n40_addr1", addr_log[1], WGT_BASE);
      check("n40_addr2", addr_log[2], ACT_BASE + 32'd4);
      check("n40_addr3", addr_log[3], WGT_BASE + 32'd4);
    end

    // Same neuron with slow grants, stalled consumer and starts while busy.
    gnt_delay = 3;
    run("n40_slow", 11'd40, 32'd0, 1'b0, 32'd24, 0, 4, 1'b1);
    gnt_delay = 0;

    // N=32 full final word: all match gives 32, half match gives 0.
    act_mem[0] = 32'h1234_5678; wgt_mem[0] = 32'h1234_5678;
    run("n32_eq", 11'd32, 32'd0, 1'b0, 32'd32, 5, 0, 1'b0);
    act_mem[0] = 32'h0000_FFFF; wgt_mem[0] = 32'h0000_0000;
    run("n32_half", 11'd32, 32'd0, 1'b0, 32'd0, 5, 0, 1'b0);

    // N=MAX_BITS: pop reaches 1024 (c = 1024), or 0 (c = -1024).
    for (int i = 0; i < 32; i++) begin
      act_mem[i] = 32'h0101_0101 * i; wgt_mem[i] = 32'h0101_0101 * i;
    end
    run("nmax_eq", 11'd1024, 32'd0, 1'b0, 32'h0000_0400, 129, 0, 1'b0);
    for (int i = 0; i < 32; i++) begin act_mem[i] = '0; wgt_mem[i] = '1; end
    run("nmax_ne", 11'd1024, 32'd0, 1'b0, 32'hFFFF_FC00, 129, 0, 1'b0);

    // Illegal widths.
    bad_start("n0", 11'd0);
    bad_start("n1025", 11'd1025);

    // Reset in WAIT_W of the second word of a 3-word neuron; stale rvalid follows.
    for (int i = 0; i < 3; i++) begin act_mem[i] = '1; wgt_mem[i] = '1; end
    g0 = ngnt;
    @(negedge clk);
    n_bits = 11'd96; en_th = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (ngnt - g0 >= 4) break;
    end
    check("mid_reach", ngnt - g0, 32'd4);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'b0, busy_o}, 32'd0);
    check("mid_rst_req", {31'b0, mem_req_o}, 32'd0);
    check("mid_rst_valid", {31'b0, res_valid_o}, 32'd0);
    check("mid_rst_err", {31'b0, err_o}, 32'd0);
    check("mid_rst_data", res_data_o, 32'd0);
    check("mid_rst_addr", mem_addr_o, 32'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("stale_busy", {31'b0, busy_o}, 32'd0);
    check("stale_req", {31'b0, mem_req_o}, 32'd0);
    check("stale_valid", {31'b0, res_valid_o}, 32'd0);

    act_mem[0] = 32'h1FF; wgt_mem[0] = 32'h1FF;
    run("post_rst", 11'd9, 32'd0, 1'b0, 32'h0000_0009, 5, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
